// File: rtl/mvm_pipe_pkg.sv
// Shared types and elaboration helpers for the mvm_pipe matrix-vector engine.
package mvm_pipe_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_X,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    // Encoding is ordered by command priority: a higher value wins.
    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_START  = 2'd1,
        CMD_LOAD_X = 2'd2,
        CMD_LOAD_A = 2'd3
    } cmd_t;

    function automatic cmd_t pick_cmd(input logic lm, input logic lv, input logic st);
        if (lm)      return CMD_LOAD_A;
        else if (lv) return CMD_LOAD_X;
        else if (st) return CMD_START;
        else         return CMD_NONE;
    endfunction

    // True when more than one command is raised, i.e. some command is dropped.
    function automatic logic cmd_dropped(input logic lm, input logic lv, input logic st);
        return (lm & (lv | st)) | (lv & st);
    endfunction

    function automatic int acc_width(input int b, input int n);
        return 2 * b + $clog2(n);
    endfunction

    function automatic int clog2w(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    function automatic bit lanes_ok(input int m, input int p);
        return (p > 0) && (m % p == 0);
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One MAC lane: registered product, accumulator seeded by the first term, and
// optional ReLU on the accumulator output.
module mvm_mac_lane
    import mvm_pipe_pkg::*;
#(
    parameter int B    = 8,
    parameter int ACCW = 18
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic signed [B-1:0]    a,
    input  logic signed [B-1:0]    x,
    input  logic                   prod_en,
    input  logic                   acc_en,
    input  logic                   first,
    input  logic                   relu_en,
    output logic signed [ACCW-1:0] y
);
    logic signed [2*B-1:0]  prod;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] term;

    assign term = ACCW'(prod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod <= '0;
            acc  <= '0;
        end else begin
            if (prod_en)
                prod <= (2*B)'(a) * (2*B)'(x);
            if (acc_en)
                acc <= first ? term : acc + term;
        end
    end

    assign y = (relu_en && acc[ACCW-1]) ? '0 : acc;

endmodule

// File: rtl/mvm_pipe.sv
// Matrix-vector multiplier y = A*x with P row-parallel MAC lanes, valid/ready
// streaming in and out, and operand reuse across repeated starts.
module mvm_pipe
    import mvm_pipe_pkg::*;
#(
    parameter int M    = 4,
    parameter int N    = 4,
    parameter int B    = 8,
    parameter int P    = 1,
    parameter int ACCW = acc_width(B, N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_matrix,
    input  logic            load_vector,
    input  logic            start,
    input  logic            relu_en,
    input  logic [B-1:0]    data_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [ACCW-1:0] data_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            done,
    output logic            busy,
    output logic            err
);
    localparam int G      = M / P;
    localparam int AD     = G * N;
    localparam int AAW    = clog2w(AD);
    localparam int KW     = clog2w(N);
    localparam int GW     = clog2w(G);
    localparam int BKW    = clog2w(P);
    localparam int STAGES = 2;

    if (!lanes_ok(M, P)) begin : g_lane_check
        $error("mvm_pipe: P must divide M");
    end

    state_t state, state_nxt;
    cmd_t   cmd;
    logic   err_nxt;
    logic   a_valid, x_valid, relu_q;

    logic [KW-1:0]  ld_col;
    logic [BKW-1:0] ld_bank;
    logic [GW-1:0]  ld_lrow;
    logic           accept, ld_last;
    logic [AAW-1:0] a_wr_addr, a_rd_addr;

    logic [KW-1:0]  k_cnt;
    logic [GW-1:0]  g_cnt;
    logic           iss_done, issue, comp_done;

    logic [STAGES:0]         vld_pipe, first_pipe, last_pipe;
    logic [STAGES:0][GW-1:0] grp_pipe;

    logic [B-1:0]    x_mem [N];
    logic [B-1:0]    rd_x;
    logic [P-1:0][ACCW-1:0] y_rd;

    logic [BKW-1:0] out_lane, rd_lane;
    logic [GW-1:0]  out_grp, rd_grp;
    logic           out_last;

    assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_X);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign a_wr_addr = AAW'(ld_lrow) * AAW'(N) + AAW'(ld_col);
    assign a_rd_addr = AAW'(g_cnt) * AAW'(N) + AAW'(k_cnt);
    assign issue     = (state == S_COMPUTE) && !iss_done;
    assign ld_last   = accept && (ld_col == KW'(N-1)) &&
                       ((state == S_LOAD_X) || (ld_bank == BKW'(P-1) && ld_lrow == GW'(G-1)));
    assign comp_done = vld_pipe[STAGES] && last_pipe[STAGES] && (grp_pipe[STAGES] == GW'(G-1));
    assign out_last  = (state == S_OUTPUT) && out_valid && out_ready &&
                       (out_lane == BKW'(P-1)) && (out_grp == GW'(G-1));
    assign done      = out_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        cmd       = pick_cmd(load_matrix, load_vector, start);
        case (state)
            S_IDLE: begin
                err_nxt = cmd_dropped(load_matrix, load_vector, start);
                case (cmd)
                    CMD_LOAD_A: state_nxt = S_LOAD_A;
                    CMD_LOAD_X: state_nxt = S_LOAD_X;
                    CMD_START:
                        if (a_valid && x_valid) state_nxt = S_COMPUTE;
                        else                    err_nxt   = 1'b1;
                    default: ;
                endcase
            end
            S_LOAD_A, S_LOAD_X: if (ld_last)   state_nxt = S_IDLE;
            S_COMPUTE:          if (comp_done) state_nxt = S_OUTPUT;
            S_OUTPUT:           if (out_last)  state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE && cmd != CMD_NONE)
            err_nxt = 1'b1;
    end

    // Next word to present: current slot on entry, following slot on acceptance.
    always_comb begin
        rd_lane = out_lane;
        rd_grp  = out_grp;
        if (out_valid) begin
            if (out_lane == BKW'(P-1)) begin
                rd_lane = '0;
                rd_grp  = out_grp + GW'(1);
            end else begin
                rd_lane = out_lane + BKW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err        <= 1'b0;
            a_valid    <= 1'b0;
            x_valid    <= 1'b0;
            relu_q     <= 1'b0;
            ld_col     <= '0;
            ld_bank    <= '0;
            ld_lrow    <= '0;
            k_cnt      <= '0;
            g_cnt      <= '0;
            iss_done   <= 1'b0;
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            grp_pipe   <= '0;
            out_valid  <= 1'b0;
            out_lane   <= '0;
            out_grp    <= '0;
            data_out   <= '0;
        end else begin
            err        <= err_nxt;
            vld_pipe   <= {vld_pipe[STAGES-1:0], issue};
            first_pipe <= {first_pipe[STAGES-1:0], k_cnt == '0};
            last_pipe  <= {last_pipe[STAGES-1:0], k_cnt == KW'(N-1)};
            grp_pipe   <= {grp_pipe[STAGES-1:0], g_cnt};

            if (state == S_IDLE) begin
                ld_col   <= '0;
                ld_bank  <= '0;
                ld_lrow  <= '0;
                k_cnt    <= '0;
                g_cnt    <= '0;
                iss_done <= 1'b0;
                if (state_nxt == S_COMPUTE) relu_q  <= relu_en;
                if (state_nxt == S_LOAD_A)  a_valid <= 1'b0;
                if (state_nxt == S_LOAD_X)  x_valid <= 1'b0;
            end

            if (accept) begin
                if (ld_col == KW'(N-1)) begin
                    ld_col <= '0;
                    if (ld_bank == BKW'(P-1)) begin
                        ld_bank <= '0;
                        ld_lrow <= ld_lrow + GW'(1);
                    end else begin
                        ld_bank <= ld_bank + BKW'(1);
                    end
                end else begin
                    ld_col <= ld_col + KW'(1);
                end
            end
            if (ld_last) begin
                if (state == S_LOAD_A) a_valid <= 1'b1;
                else                   x_valid <= 1'b1;
            end

            if (issue) begin
                if (k_cnt == KW'(N-1)) begin
                    k_cnt <= '0;
                    if (g_cnt == GW'(G-1)) iss_done <= 1'b1;
                    else                   g_cnt    <= g_cnt + GW'(1);
                end else begin
                    k_cnt <= k_cnt + KW'(1);
                end
            end

            if (state == S_OUTPUT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    data_out  <= y_rd[rd_lane];
                end else if (out_ready) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                    end else begin
                        out_lane <= rd_lane;
                        out_grp  <= rd_grp;
                        data_out <= y_rd[rd_lane];
                    end
                end
            end else begin
                out_lane <= '0;
                out_grp  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && state == S_LOAD_X)
            x_mem[ld_col] <= data_in;
        if (issue)
            rd_x <= x_mem[k_cnt];
    end

    // Lane l owns matrix rows l, l+P, ... and the matching y slots.
    for (genvar l = 0; l < P; l++) begin : g_lane
        logic [B-1:0]    bank  [AD];
        logic [ACCW-1:0] ybank [G];
        logic [B-1:0]    rd_a;
        logic [ACCW-1:0] lane_y;

        always_ff @(posedge clk) begin
            if (accept && state == S_LOAD_A && ld_bank == BKW'(l))
                bank[a_wr_addr] <= data_in;
            if (issue)
                rd_a <= bank[a_rd_addr];
            if (vld_pipe[STAGES] && last_pipe[STAGES])
                ybank[grp_pipe[STAGES]] <= lane_y;
        end

        mvm_mac_lane #(.B(B), .ACCW(ACCW)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .a       (rd_a),
            .x       (rd_x),
            .prod_en (vld_pipe[0]),
            .acc_en  (vld_pipe[1]),
            .first   (first_pipe[1]),
            .relu_en (relu_q),
            .y       (lane_y)
        );

        assign y_rd[l] = ybank[rd_grp];
    end

endmodule

// File: tb/tb_mvm_pipe.sv
// Directed bench for mvm_pipe: vector table for the arithmetic plus hand
// sequences for backpressure, command errors and mid-compute reset.
module tb_mvm_pipe;
    localparam int M = 4, N = 4, B = 8, P = 2, ACCW = 18;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0, relu_en = 1'b0;
    logic [B-1:0]    data_in = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [ACCW-1:0] data_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            done, busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mvm_pipe #(.M(M), .N(N), .B(B), .P(P), .ACCW(ACCW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_matrix (load_matrix),
        .load_vector (load_vector),
        .start       (start),
        .relu_en     (relu_en),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done),
        .busy        (busy),
        .err         (err)
    );

    typedef struct {
        string            name;
        bit               ld_a;
        bit               ld_x;
        logic [15:0][7:0] a;
        logic [3:0][7:0]  x;
        bit               relu;
        logic [3:0][17:0] y;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic command(input bit lm, input bit lv, input bit st, input bit re);
        load_matrix = lm; load_vector = lv; start = st; relu_en = re;
        @(negedge clk);
        load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0; relu_en = 1'b0;
    endtask

    task automatic push(input logic [7:0] w);
        int t = 0;
        data_in = w; in_valid = 1'b1;
        #1;
        while (!in_ready && t < 50) begin @(negedge clk); #1; t++; end
        chk("in_ready during load", longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_a(input logic [15:0][7:0] a);
        command(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < M*N; i++) begin
            if (i % 5 == 4) @(negedge clk);
            push(a[i]);
        end
    endtask

    task automatic load_x(input logic [3:0][7:0] x);
        command(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i == 2) @(negedge clk);
            push(x[i]);
        end
    endtask

    task automatic run(input string nm, input bit re, input logic [3:0][17:0] y, input logic [6:0] pat);
        int lat = 0, idx = 0, cyc = 0, ndone = 0;
        bit stalled = 1'b0;
        logic [17:0] held = '0;
        command(1'b0, 1'b0, 1'b1, re);
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({nm, " first out_valid latency"}, longint'(lat), 12);
        while (idx < M && cyc < 100) begin
            out_ready = pat[cyc % 7];
            #1;
            chk({nm, " out_valid held"}, longint'(out_valid), 1);
            if (stalled) chk({nm, " data_out stable in stall"}, longint'(data_out), longint'(held));
            chk({nm, " done"}, longint'(done), longint'(out_ready && idx == M-1));
            stalled = !out_ready;
            held    = data_out;
            if (out_ready) begin
                chk($sformatf("%s y[%0d]", nm, idx), longint'($signed(data_out)), longint'($signed(y[idx])));
                if (done) ndone++;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk({nm, " done pulses"}, longint'(ndone), 1);
        chk({nm, " busy after done"}, longint'(busy), 0);
        chk({nm, " out_valid after done"}, longint'(out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[7];
        logic [7:0] r4 [16];

        r4 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'hff, 8'd0, 8'd1, 8'd0,
               8'd5, 8'hfb, 8'd5, 8'hfb, 8'h7f, 8'h7f, 8'h7f, 8'h7f};

        v[0] = '{name: "identity", ld_a: 1, ld_x: 1, a: '0, x: {8'd4, 8'd3, 8'd2, 8'd1},
                 relu: 0, y: {18'd4, 18'd3, 18'd2, 18'd1}};
        for (int i = 0; i < 4; i++) v[0].a[i*5] = 8'd1;
        v[1] = '{name: "extreme neg*neg", ld_a: 1, ld_x: 1, a: {16{8'h80}}, x: {4{8'h80}},
                 relu: 0, y: {4{18'd65536}}};
        v[2] = '{name: "neg identity relu", ld_a: 1, ld_x: 1, a: '0, x: {8'hfc, 8'h03, 8'hfe, 8'h01},
                 relu: 1, y: {18'd4, 18'd0, 18'd2, 18'd0}};
        for (int i = 0; i < 4; i++) v[2].a[i*5] = 8'hff;
        v[3] = '{name: "restart no relu", ld_a: 0, ld_x: 0, a: '0, x: '0,
                 relu: 0, y: {18'd4, 18'h3fffd, 18'd2, 18'h3ffff}};
        v[4] = '{name: "general", ld_a: 1, ld_x: 1, a: '0, x: {8'hff, 8'd2, 8'd1, 8'd1},
                 relu: 0, y: {18'd381, 18'd15, 18'd1, 18'd5}};
        for (int i = 0; i < 16; i++) v[4].a[i] = r4[i];
        v[5] = '{name: "max pos*neg", ld_a: 1, ld_x: 1, a: {16{8'h7f}}, x: {4{8'h80}},
                 relu: 0, y: {4{18'h30200}}};
        v[6] = '{name: "reuse relu clamp", ld_a: 0, ld_x: 0, a: '0, x: '0,
                 relu: 1, y: '0};

        repeat (2) @(negedge clk);
        chk("reset in_ready", longint'(in_ready), 0);
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset done", longint'(done), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset err", longint'(err), 0);
        chk("reset data_out", longint'(data_out), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // start with no operands loaded
        command(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start w/o operands err", longint'(err), 1);
        chk("start w/o operands busy", longint'(busy), 0);
        @(negedge clk);
        chk("err is one cycle", longint'(err), 0);
        chk("still idle", longint'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            if (v[i].ld_a) load_a(v[i].a);
            if (v[i].ld_x) load_x(v[i].x);
            run(v[i].name, v[i].relu, v[i].y, 7'h7f);
        end

        // output backpressure, ready pattern 1,0,0,1,0,1,1
        load_a(v[0].a);
        load_x(v[0].x);
        run("backpressure", 1'b0, v[0].y, 7'b1101001);

        // load_matrix + start together, then load_vector mid-load
        command(1'b1, 1'b0, 1'b1, 1'b0);
        chk("lm+start err", longint'(err), 1);
        chk("lm+start enters load", longint'(busy), 1);
        chk("lm+start in_ready", longint'(in_ready), 1);
        for (int i = 0; i < M*N; i++) begin
            if (i == 7) load_vector = 1'b1;
            push(v[4].a[i]);
            if (i == 7) begin
                load_vector = 1'b0;
                chk("lv during load err", longint'(err), 1);
                chk("lv during load busy", longint'(busy), 1);
            end
        end
        chk("load done returns idle", longint'(busy), 0);
        load_x(v[4].x);
        run("after rejected cmds", 1'b0, v[4].y, 7'h7f);

        // reset in the middle of a compute
        command(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("computing busy", longint'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset busy", longint'(busy), 0);
        chk("async reset out_valid", longint'(out_valid), 0);
        chk("async reset in_ready", longint'(in_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        command(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start after abort err", longint'(err), 1);
        chk("start after abort busy", longint'(busy), 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
